// File: rtl/sensor_request_conditioner.sv
// Conditions raw pedestrian buttons and lane loop sensors into sticky request bits
// for the intersection controller, plus per-crosswalk wait counters.
module sensor_request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PRESENCE_CYCLES = 8,
  parameter int WAIT_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              straight_street_pedestrian_button,
  input  logic              cross_street_pedestrian_button,
  input  logic              straight_street_straight_lane_car_sensor,
  input  logic              straight_street_turn_lane_car_sensor,
  input  logic              cross_street_straight_lane_car_sensor,
  input  logic              cross_street_turn_lane_car_sensor,
  input  logic [5:0]        served,
  output logic [5:0]        request,
  output logic [WAIT_W-1:0] straight_street_wait,
  output logic [WAIT_W-1:0] cross_street_wait
);

  localparam int NUM_IN  = 6;
  localparam int NUM_CAR = 4;
  localparam int SS_PED  = 5;
  localparam int CS_PED  = 4;

  localparam logic [7:0]        DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]        PC_LAST  = 8'(PRESENCE_CYCLES - 1);
  localparam logic [7:0]        PC_FULL  = 8'(PRESENCE_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_MAX = {WAIT_W{1'b1}};

  logic [NUM_IN-1:0]  w_raw;
  logic [NUM_IN-1:0]  r_s1;
  logic [NUM_IN-1:0]  r_s2;
  logic [NUM_IN-1:0]  r_deb;
  logic [7:0]         r_deb_cnt [NUM_IN];
  logic [1:0]         r_ped_deb_q;
  logic [1:0]         w_ped_rise;
  logic [7:0]         r_pc [NUM_CAR];
  logic [NUM_CAR-1:0] w_car_qual;
  logic [NUM_IN-1:0]  r_req;
  logic [WAIT_W-1:0]  r_ss_wait;
  logic [WAIT_W-1:0]  r_cs_wait;

  // Packed in the same bit order as served/request.
  assign w_raw = {straight_street_pedestrian_button,
                  cross_street_pedestrian_button,
                  straight_street_straight_lane_car_sensor,
                  straight_street_turn_lane_car_sensor,
                  cross_street_straight_lane_car_sensor,
                  cross_street_turn_lane_car_sensor};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_deb <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        r_deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_LAST) begin
          r_deb[i]     <= r_s2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Previous debounced level of the two buttons, for press edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ped_deb_q <= '0;
    end else begin
      r_ped_deb_q <= r_deb[SS_PED:CS_PED];
    end
  end

  assign w_ped_rise = r_deb[SS_PED:CS_PED] & ~r_ped_deb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CAR; i++) begin
        r_pc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CAR; i++) begin
        if (served[i] || !r_deb[i]) begin
          r_pc[i] <= '0;
        end else if (r_pc[i] < PC_FULL) begin
          r_pc[i] <= r_pc[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    w_car_qual = '0;
    for (int i = 0; i < NUM_CAR; i++) begin
      w_car_qual[i] = r_deb[i] && (r_pc[i] == PC_LAST);
    end
  end

  // Buttons: a new press beats a same-edge serve. Cars: the serve wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (w_ped_rise[j]) begin
          r_req[CS_PED+j] <= 1'b1;
        end else if (served[CS_PED+j]) begin
          r_req[CS_PED+j] <= 1'b0;
        end
      end
      for (int i = 0; i < NUM_CAR; i++) begin
        if (served[i]) begin
          r_req[i] <= 1'b0;
        end else if (w_car_qual[i]) begin
          r_req[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ss_wait <= '0;
    end else if (w_ped_rise[1] || served[SS_PED]) begin
      r_ss_wait <= '0;
    end else if (r_req[SS_PED] && (r_ss_wait != WAIT_MAX)) begin
      r_ss_wait <= r_ss_wait + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs_wait <= '0;
    end else if (w_ped_rise[0] || served[CS_PED]) begin
      r_cs_wait <= '0;
    end else if (r_req[CS_PED] && (r_cs_wait != WAIT_MAX)) begin
      r_cs_wait <= r_cs_wait + 1'b1;
    end
  end

  assign request              = r_req;
  assign straight_street_wait = r_ss_wait;
  assign cross_street_wait    = r_cs_wait;

endmodule

// File: tb/tb_sensor_request_conditioner.sv
// Bench for sensor_request_conditioner: expected request/wait values are queued per
// edge (relative to the end of a reset) and compared on the falling edge after it.
module tb_sensor_request_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic       ss_btn, cs_btn, ss_st, ss_tn, cs_st, cs_tn;
  logic [5:0] served_r;
  logic [5:0] request;
  logic [7:0] straight_street_wait;
  logic [7:0] cross_street_wait;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         e;
    logic [5:0] mask;
    logic [5:0] req;
    bit         chk_w;
    logic [7:0] ssw;
    logic [7:0] csw;
  } exp_t;

  exp_t sbq[$];

  sensor_request_conditioner dut (
    .clk                                      (clk),
    .reset                                    (reset),
    .straight_street_pedestrian_button        (ss_btn),
    .cross_street_pedestrian_button           (cs_btn),
    .straight_street_straight_lane_car_sensor (ss_st),
    .straight_street_turn_lane_car_sensor     (ss_tn),
    .cross_street_straight_lane_car_sensor    (cs_st),
    .cross_street_turn_lane_car_sensor        (cs_tn),
    .served                                   (served_r),
    .request                                  (request),
    .straight_street_wait                     (straight_street_wait),
    .cross_street_wait                        (cross_street_wait)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic void push_exp(int e, logic [5:0] mask, logic [5:0] req, bit chk_w,
                                   logic [7:0] ssw, logic [7:0] csw);
    exp_t x;
    x.e = e; x.mask = mask; x.req = req; x.chk_w = chk_w; x.ssw = ssw; x.csw = csw;
    sbq.push_back(x);
  endfunction

  task automatic drive_idle();
    ss_btn = 0; cs_btn = 0; ss_st = 0; ss_tn = 0; cs_st = 0; cs_tn = 0; served_r = '0;
  endtask

  // Leaves the bench on a falling edge with reset already released: relative edge 1 is next.
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if (request !== 6'b0) begin
      n_fail++; $display("FAIL reset_request: got %b want 000000", request);
    end
    n_tests++;
    if (straight_street_wait !== 8'd0 || cross_street_wait !== 8'd0) begin
      n_fail++; $display("FAIL reset_wait: got ss=%0d cs=%0d want 0 0", straight_street_wait, cross_street_wait);
    end
    reset = 0;
    repeat (5) @(negedge clk);
    n_tests++;
    if (request !== 6'b0) begin
      n_fail++; $display("FAIL reset_idle: got %b want 000000", request);
    end
  endtask

  // ss_ped raw high from edge 10 for 40 cycles: request after edge 28, wait counts from 29.
  task automatic test_ped_latency();
    exp_t ex;
    for (int r = 1; r <= 60; r++)
      push_exp(r, 6'h3F, (r >= 28) ? 6'h20 : 6'h00, 1'b1, (r >= 28) ? 8'(r - 28) : 8'd0, 8'd0);
    do_reset();
    for (int r = 0; r <= 60; r++) begin
      if (r > 0) begin
        @(negedge clk);
        while (sbq.size() > 0 && sbq[0].e <= r) begin
          ex = sbq.pop_front();
          n_tests++;
          if ((request & ex.mask) !== ex.req || ex.e != r) begin
            n_fail++; $display("FAIL ped_latency req @%0d: got %b want %b", ex.e, request & ex.mask, ex.req);
          end
          if (ex.chk_w) begin
            n_tests++;
            if (straight_street_wait !== ex.ssw || cross_street_wait !== ex.csw) begin
              n_fail++; $display("FAIL ped_latency wait @%0d: got ss=%0d cs=%0d want ss=%0d cs=%0d",
                                 ex.e, straight_street_wait, cross_street_wait, ex.ssw, ex.csw);
            end
          end
        end
      end
      if (r == 9)  ss_btn = 1;
      if (r == 49) ss_btn = 0;
    end
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++; $display("FAIL ped_latency leftover: got %0d pending want 0", sbq.size()); sbq.delete();
    end
  endtask

  // cs_straight high for hi_len cycles from edge 1: 15 is a glitch, 16 just qualifies.
  task automatic test_debounce(int hi_len, int n_cyc);
    exp_t ex;
    for (int r = 1; r <= n_cyc; r++)
      push_exp(r, 6'h3F, (hi_len >= 16 && r >= 26) ? 6'h02 : 6'h00, 1'b1, 8'd0, 8'd0);
    do_reset();
    for (int r = 0; r <= n_cyc; r++) begin
      if (r > 0) begin
        @(negedge clk);
        while (sbq.size() > 0 && sbq[0].e <= r) begin
          ex = sbq.pop_front();
          n_tests++;
          if ((request & ex.mask) !== ex.req || ex.e != r) begin
            n_fail++; $display("FAIL debounce_%0d req @%0d: got %b want %b", hi_len, ex.e, request & ex.mask, ex.req);
          end
          if (ex.chk_w) begin
            n_tests++;
            if (straight_street_wait !== ex.ssw || cross_street_wait !== ex.csw) begin
              n_fail++; $display("FAIL debounce_%0d wait @%0d: got ss=%0d cs=%0d want 0 0",
                                 hi_len, ex.e, straight_street_wait, cross_street_wait);
            end
          end
        end
      end
      if (r == 0)      cs_st = 1;
      if (r == hi_len) cs_st = 0;
    end
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++; $display("FAIL debounce_%0d leftover: got %0d pending want 0", hi_len, sbq.size()); sbq.delete();
    end
  endtask

  // cs_turn and ss_turn held from edge 1. served[0] at edge 41 clears and re-qualifies at 49.
  // served[2] lands on ss_turn's qualifying edge 26: serve wins, request appears at 34.
  task automatic test_car_served();
    exp_t ex;
    logic [5:0] q;
    for (int r = 1; r <= 70; r++) begin
      q = '0;
      q[0] = ((r >= 26) && (r <= 40)) || (r >= 49);
      q[2] = (r >= 34);
      push_exp(r, 6'h3F, q, 1'b1, 8'd0, 8'd0);
    end
    do_reset();
    for (int r = 0; r <= 70; r++) begin
      if (r > 0) begin
        @(negedge clk);
        while (sbq.size() > 0 && sbq[0].e <= r) begin
          ex = sbq.pop_front();
          n_tests++;
          if ((request & ex.mask) !== ex.req || ex.e != r) begin
            n_fail++; $display("FAIL car_served req @%0d: got %b want %b", ex.e, request & ex.mask, ex.req);
          end
          if (ex.chk_w) begin
            n_tests++;
            if (straight_street_wait !== ex.ssw || cross_street_wait !== ex.csw) begin
              n_fail++; $display("FAIL car_served wait @%0d: got ss=%0d cs=%0d want 0 0",
                                 ex.e, straight_street_wait, cross_street_wait);
            end
          end
        end
      end
      if (r == 0)  begin cs_tn = 1; ss_tn = 1; end
      if (r == 25) served_r = 6'b000100;
      if (r == 26) served_r = 6'b000000;
      if (r == 40) served_r = 6'b000001;
      if (r == 41) served_r = 6'b000000;
    end
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++; $display("FAIL car_served leftover: got %0d pending want 0", sbq.size()); sbq.delete();
    end
  endtask

  // ss_ped held from edge 1 (request at 19); wait saturates at 255; served[5] at edge 331.
  task automatic test_wait_saturate();
    exp_t ex;
    bit on;
    int w;
    for (int r = 1; r <= 345; r++) begin
      on = (r >= 19) && (r <= 330);
      w  = on ? ((r - 19 > 255) ? 255 : r - 19) : 0;
      push_exp(r, 6'h3F, on ? 6'h20 : 6'h00, 1'b1, 8'(w), 8'd0);
    end
    do_reset();
    for (int r = 0; r <= 345; r++) begin
      if (r > 0) begin
        @(negedge clk);
        while (sbq.size() > 0 && sbq[0].e <= r) begin
          ex = sbq.pop_front();
          n_tests++;
          if ((request & ex.mask) !== ex.req || ex.e != r) begin
            n_fail++; $display("FAIL wait_saturate req @%0d: got %b want %b", ex.e, request & ex.mask, ex.req);
          end
          if (ex.chk_w) begin
            n_tests++;
            if (straight_street_wait !== ex.ssw || cross_street_wait !== ex.csw) begin
              n_fail++; $display("FAIL wait_saturate wait @%0d: got ss=%0d cs=%0d want ss=%0d cs=%0d",
                                 ex.e, straight_street_wait, cross_street_wait, ex.ssw, ex.csw);
            end
          end
        end
      end
      if (r == 0)   ss_btn = 1;
      if (r == 330) served_r = 6'b100000;
      if (r == 331) served_r = 6'b000000;
    end
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++; $display("FAIL wait_saturate leftover: got %0d pending want 0", sbq.size()); sbq.delete();
    end
  endtask

  // cs_ped pressed, released, re-pressed so its debounced rise lands on edge 59 with served[4].
  task automatic test_ped_collision();
    exp_t ex;
    int w;
    for (int r = 1; r <= 70; r++) begin
      w = (r < 19) ? 0 : ((r < 59) ? r - 19 : r - 59);
      push_exp(r, 6'h3F, (r >= 19) ? 6'h10 : 6'h00, 1'b1, 8'd0, 8'(w));
    end
    do_reset();
    for (int r = 0; r <= 70; r++) begin
      if (r > 0) begin
        @(negedge clk);
        while (sbq.size() > 0 && sbq[0].e <= r) begin
          ex = sbq.pop_front();
          n_tests++;
          if ((request & ex.mask) !== ex.req || ex.e != r) begin
            n_fail++; $display("FAIL ped_collision req @%0d: got %b want %b", ex.e, request & ex.mask, ex.req);
          end
          if (ex.chk_w) begin
            n_tests++;
            if (straight_street_wait !== ex.ssw || cross_street_wait !== ex.csw) begin
              n_fail++; $display("FAIL ped_collision wait @%0d: got ss=%0d cs=%0d want ss=%0d cs=%0d",
                                 ex.e, straight_street_wait, cross_street_wait, ex.ssw, ex.csw);
            end
          end
        end
      end
      if (r == 0)  cs_btn = 1;
      if (r == 20) cs_btn = 0;
      if (r == 40) cs_btn = 1;
      if (r == 58) served_r = 6'b010000;
      if (r == 59) served_r = 6'b000000;
    end
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++; $display("FAIL ped_collision leftover: got %0d pending want 0", sbq.size()); sbq.delete();
    end
  endtask

  // Everything held from edge 1, reset at edge 31, all served at edge 60,
  // buttons released at 81 and re-pressed at 101.
  task automatic test_reset_mid();
    exp_t ex;
    logic [5:0] q;
    int w;
    bit ped, car;
    for (int r = 1; r <= 125; r++) begin
      if (r <= 30) begin
        ped = (r >= 19);
        car = (r >= 26);
        w   = ped ? r - 19 : 0;
      end else begin
        ped = ((r >= 50) && (r <= 59)) || (r >= 119);
        car = ((r >= 57) && (r <= 59)) || (r >= 68);
        w   = ((r >= 50) && (r <= 59)) ? r - 50 : ((r >= 119) ? r - 119 : 0);
      end
      q = {ped, ped, car, car, car, car};
      push_exp(r, 6'h3F, q, 1'b1, 8'(w), 8'(w));
    end
    do_reset();
    for (int r = 0; r <= 125; r++) begin
      if (r > 0) begin
        @(negedge clk);
        while (sbq.size() > 0 && sbq[0].e <= r) begin
          ex = sbq.pop_front();
          n_tests++;
          if ((request & ex.mask) !== ex.req || ex.e != r) begin
            n_fail++; $display("FAIL reset_mid req @%0d: got %b want %b", ex.e, request & ex.mask, ex.req);
          end
          if (ex.chk_w) begin
            n_tests++;
            if (straight_street_wait !== ex.ssw || cross_street_wait !== ex.csw) begin
              n_fail++; $display("FAIL reset_mid wait @%0d: got ss=%0d cs=%0d want ss=%0d cs=%0d",
                                 ex.e, straight_street_wait, cross_street_wait, ex.ssw, ex.csw);
            end
          end
        end
      end
      if (r == 0)   begin ss_btn = 1; cs_btn = 1; ss_st = 1; ss_tn = 1; cs_st = 1; cs_tn = 1; end
      if (r == 30)  reset = 1;
      if (r == 31)  reset = 0;
      if (r == 59)  served_r = 6'h3F;
      if (r == 60)  served_r = 6'h00;
      if (r == 80)  begin ss_btn = 0; cs_btn = 0; end
      if (r == 100) begin ss_btn = 1; cs_btn = 1; end
    end
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++; $display("FAIL reset_mid leftover: got %0d pending want 0", sbq.size()); sbq.delete();
    end
  endtask

  initial begin
    reset = 1;
    drive_idle();
    test_reset();
    test_ped_latency();
    test_debounce(15, 200);
    test_debounce(16, 60);
    test_car_served();
    test_wait_saturate();
    test_ped_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_request_conditioner.md
Name: sensor_request_conditioner

Overview:
- Front-end stage feeding the intersection controller's request inputs.
- Synchronizes and debounces the 2 raw pedestrian buttons and 4 raw lane car sensors.
- Latches pedestrian presses and qualified car presence as sticky requests, held until the controller pulses the matching served input.
- Reports how long each pedestrian request has waited, so the controller can prioritize.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles needed to change a debounced level (range 2..255).
- PRESENCE_CYCLES, 8, consecutive debounced-high cycles needed before a car sensor raises a request (range 1..255).
- WAIT_W, 8, width of the pedestrian wait counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- straight_street_pedestrian_button  in  1  raw button, asynchronous.
- cross_street_pedestrian_button  in  1  raw button, asynchronous.
- straight_street_straight_lane_car_sensor  in  1  raw loop sensor, asynchronous.
- straight_street_turn_lane_car_sensor  in  1  raw loop sensor, asynchronous.
- cross_street_straight_lane_car_sensor  in  1  raw loop sensor, asynchronous.
- cross_street_turn_lane_car_sensor  in  1  raw loop sensor, asynchronous.
- served  in  6  one-cycle clear pulses from controller. Bit order {ss_ped, cs_ped, ss_straight, ss_turn, cs_straight, cs_turn}, bit 5 = ss_ped.
- request  out  6  sticky requests, same bit order as served.
- straight_street_wait  out  WAIT_W  cycles the ss_ped request has been pending.
- cross_street_wait  out  WAIT_W  cycles the cs_ped request has been pending.

Behaviour:
- Reset (synchronous; also when asserted mid-operation):
  - All synchronizer flops, debounced levels, debounce counters, presence counters, request, and both wait counters go to 0 on the next edge.
  - Raw inputs held high through reset are treated as new presses after release.
- Synchronizer: 2 flops per raw input (s1, s2).
- Debounce, per input: 8-bit counter cnt and debounced level deb.
  - s2 == deb: cnt <= 0.
  - s2 != deb and cnt == DEBOUNCE_CYCLES-1: deb <= s2, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - A mismatch lasting fewer than DEBOUNCE_CYCLES cycles never changes deb.
- Pedestrian request:
  - Set on a rising edge of deb (deb high, previous deb low).
  - Cleared when the served bit is 1.
  - Simultaneous set and served: set wins, request stays 1.
  - Holding the button does not re-request; a release plus debounced re-press is required.
- Car request:
  - Per-lane presence counter pc: deb low -> pc <= 0; deb high and pc < PRESENCE_CYCLES -> pc <= pc+1.
  - Request set on the edge where pc goes PRESENCE_CYCLES-1 -> PRESENCE_CYCLES.
  - Served pulse clears the request and resets pc to 0. If the car is still present, the request reasserts PRESENCE_CYCLES cycles later.
  - Simultaneous qualify and served: served wins, and pc restarts from 0.
- Wait counters:
  - Increment by 1 every cycle the matching pedestrian request is 1.
  - Saturate at 2^WAIT_W-1 (no wrap).
  - Go to 0 on the same edge the request clears.
  - A same-edge set-wins collision also zeroes the counter (new request).
- Latency, with k = the first edge sampling raw high:
  - Pedestrian request asserts after edge k+DEBOUNCE_CYCLES+2 (18 with defaults).
  - Car request asserts after edge k+DEBOUNCE_CYCLES+PRESENCE_CYCLES+1 (25 with defaults).
- Served pulses on bits whose request is 0 have no effect, apart from resetting pc.

Test Plan:
- Defaults, raw ss_ped button high from edge 10, held 40 cycles -> request[5] = 1 after edge 28, never earlier. straight_street_wait = 1 after edge 29 and counts up by 1 per cycle.
- Raw cs_straight sensor pulses high for 15 cycles, then low -> deb never rises, request[1] stays 0 for 200 cycles.
- Raw cs_turn sensor held high from edge 0, served[0] pulsed at edge 40 -> request[0] first set after edge 25, clears after edge 40, reasserts after edge 48.
- ss_ped request pending for 300 cycles -> straight_street_wait saturates at 255 and holds. A served[5] pulse returns the request and the wait counter to 0 on that edge.
- Rising deb of cs_ped on the same edge as a served[4] pulse -> request[4] stays 1 and cross_street_wait restarts at 0.
- All inputs active with requests pending, reset high for 1 cycle -> request = 6'b0 and both waits = 0 after that edge. A held button does not re-request until released and re-pressed.
